btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of clock cycles a raw level must stay stable before it is accepted (10 ms at 50 MHz).
REQ-002 The module SHALL have parameter TEST_HOLD_CYCLES, default 250000000, the number of cycles the test button must be held, measured from the accepted press (5 s at 50 MHz).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have ports btn_feed, btn_heal, btn_change and btn_test, input, 1 bit each: raw, asynchronous, active-low board buttons (0 = pressed).
REQ-006 The module SHALL have ports feeding, healing, change_state and test, output, 1 bit each: active-high, single-cycle command pulses for the pet-state FSM.

Function
REQ-007 Each raw button SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-008 Each button SHALL have an independent debouncer: a debounced level and a counter sized $clog2(DEBOUNCE_CYCLES+1).
- When the synchronized level differs from the debounced level, the counter increments.
- When it equals the debounced level, the counter clears.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
REQ-009 A debounced press (falling edge of the debounced level) on feed, heal or change SHALL produce a 1-cycle pulse on the matching output.
- The pulse is registered and appears DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the pressed raw level.
REQ-010 Releases SHALL never produce pulses, and a held button SHALL produce exactly one pulse per press.
REQ-011 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and SHALL leave the debounced level unchanged.
REQ-012 The test button SHALL use a 3-state FSM: IDLE, HOLD and FIRED.
- IDLE -> HOLD on a debounced press; the hold counter clears.
- HOLD: the hold counter increments each cycle.
- HOLD -> IDLE on a debounced release before the counter reaches TEST_HOLD_CYCLES; no pulse.
- HOLD -> FIRED when the counter reaches TEST_HOLD_CYCLES; test pulses for 1 cycle on that transition.
- FIRED -> IDLE on a debounced release; no further pulse until a new press.
REQ-013 The hold counter SHALL be $clog2(TEST_HOLD_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-014 Outputs SHALL be one-hot or zero in every cycle.
- If more than one pulse is due in the same cycle, only the highest priority one is emitted: test > healing > feeding > change_state.
- Lower-priority pulses due in that cycle are discarded, not queued.
REQ-015 Holding the test button SHALL NOT block or delay pulses from the other three buttons, except as priority requires in the single cycle test fires.
REQ-016 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input.

Reset
REQ-017 While rst = 0, all synchronizer flops and debounced levels SHALL be 1 (released).
REQ-018 While rst = 0, all counters SHALL be 0, the test FSM SHALL be IDLE, and all four outputs SHALL be 0.
REQ-019 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse.
- After rst returns to 1, a button still held low SHALL be treated as a new press and produce its pulse after the full latency of REQ-009, or after the full hold time for the test button.
REQ-020 Reset SHALL take effect asynchronously; release SHALL be sampled synchronously by the internal logic.

Verification (DEBOUNCE_CYCLES=4, TEST_HOLD_CYCLES=20)
REQ-021 Clean press: btn_feed low and held for 30 cycles -> feeding high for exactly 1 cycle, 7 edges after the first sampling edge; no pulse on release.
REQ-022 Bounce: btn_heal toggles low/high every 2 cycles 5 times, then is held low -> no pulse during bouncing; exactly one healing pulse 7 edges after the final stable low.
REQ-023 Test hold: btn_test held 40 cycles -> test pulses once, 20 cycles after the debounced press; btn_test held 10 cycles then released -> no test pulse.
REQ-024 Simultaneous press: btn_feed and btn_change fall on the same edge -> feeding pulses once and change_state never pulses for that press.
REQ-025 Reset mid-hold: btn_test held, rst driven to 0 at hold count 10 for 3 cycles, button still held -> no pulse; test pulses 4+3+20 cycles after rst returns high.
REQ-026 Concurrency: btn_test held while btn_feed is pressed and released twice -> two feeding pulses, then one test pulse, with outputs never high together.

Source files
------------

// File: rtl/btn_conditioner.sv
// Button conditioner for the pet-state controller.
//
// Takes four raw, active-low board buttons and turns each debounced press into a
// single-cycle, active-high command pulse. Feed, heal and change pulse on every
// debounced press. Test pulses only once the button has been held for
// TEST_HOLD_CYCLES after its debounced press. At most one output is high in any
// cycle, with priority test > healing > feeding > change_state. A pulse that loses
// the priority check is dropped, not queued.
//
// Parameters:
//   DEBOUNCE_CYCLES  - cycles a synchronized level must stay stable before it is accepted
//   TEST_HOLD_CYCLES - cycles the test button must stay held after its debounced press
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   btn_feed     - raw feed button, active low
//   btn_heal     - raw heal button, active low
//   btn_change   - raw change button, active low
//   btn_test     - raw test button, active low
//   feeding      - one-cycle pulse on a debounced feed press
//   healing      - one-cycle pulse on a debounced heal press
//   change_state - one-cycle pulse on a debounced change press
//   test         - one-cycle pulse once the test button has been held long enough
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned TEST_HOLD_CYCLES = 250000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_feed,
  input  logic btn_heal,
  input  logic btn_change,
  input  logic btn_test,
  output logic feeding,
  output logic healing,
  output logic change_state,
  output logic test
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(TEST_HOLD_CYCLES + 1);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE_CYCLES);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(TEST_HOLD_CYCLES);

  // Bit positions of each button in the internal vectors.
  localparam int unsigned BFeed   = 0;
  localparam int unsigned BHeal   = 1;
  localparam int unsigned BChange = 2;
  localparam int unsigned BTest   = 3;

  typedef enum logic [1:0] {StIdle, StHold, StFired} test_st_e;

  logic [3:0]      btn_raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      deb_q, deb_d;
  logic [DebW-1:0] deb_cnt_q [4];
  logic [DebW-1:0] deb_cnt_d [4];
  logic [3:0]      press_evt;
  logic            test_release;
  logic            test_fire;

  test_st_e         test_st_q;
  logic [HoldW-1:0] hold_cnt_q;

  assign btn_raw = {btn_test, btn_change, btn_heal, btn_feed};

  // Two-flop synchronizers; reset to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: count consecutive cycles the synchronized level disagrees with the
  // accepted level; accept it on the cycle after the count has reached the limit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '1;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Press/release events are taken on the edge the debounced level changes, so the
  // registered pulse lands on that same edge.
  assign press_evt    = deb_q & ~deb_d;
  assign test_release = ~deb_q[BTest] & deb_d[BTest];

  // Test fires on the edge that brings the hold count up to TEST_HOLD_CYCLES; a
  // release seen on that same edge wins and aborts the hold.
  assign test_fire = (test_st_q == StHold) && !test_release &&
                     (hold_cnt_q == HoldMax - 1'b1);

  // Test-hold FSM plus the registered, priority-encoded command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      test_st_q    <= StIdle;
      hold_cnt_q   <= '0;
      test         <= 1'b0;
      healing      <= 1'b0;
      feeding      <= 1'b0;
      change_state <= 1'b0;
    end else begin
      case (test_st_q)
        StIdle: begin
          if (press_evt[BTest]) begin
            test_st_q  <= StHold;
            hold_cnt_q <= '0;
          end
        end
        StHold: begin
          if (test_release) begin
            test_st_q <= StIdle;
          end else begin
            if (hold_cnt_q != HoldMax) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (test_fire) begin
              test_st_q <= StFired;
            end
          end
        end
        StFired: begin
          if (test_release) begin
            test_st_q <= StIdle;
          end
        end
        default: test_st_q <= StIdle;
      endcase

      // Lower-priority pulses colliding with a higher one are discarded.
      test         <= test_fire;
      healing      <= !test_fire && press_evt[BHeal];
      feeding      <= !test_fire && !press_evt[BHeal] && press_evt[BFeed];
      change_state <= !test_fire && !press_evt[BHeal] && !press_evt[BFeed] &&
                      press_evt[BChange];
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4, TEST_HOLD_CYCLES=20.
// A reference model accepts a new button level once the last DEB+1 synchronized
// samples all disagree with the accepted level, and fires test once the accepted
// test level has stayed low for HOLD edges after its press.
module tb_btn_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic btn_feed   = 1'b1;
  logic btn_heal   = 1'b1;
  logic btn_change = 1'b1;
  logic btn_test   = 1'b1;
  logic feeding, healing, change_state, test;
  logic [3:0] dut_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  assign dut_out = {test, healing, feeding, change_state};

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .TEST_HOLD_CYCLES(HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_feed    (btn_feed),
    .btn_heal    (btn_heal),
    .btn_change  (btn_change),
    .btn_test    (btn_test),
    .feeding     (feeding),
    .healing     (healing),
    .change_state(change_state),
    .test        (test)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- reference model
  typedef struct packed {
    logic [3:0][DEB+1:0] hist;  // hist[b][k]: raw sample of button b taken k+1 edges ago
    logic [3:0]          deb;   // accepted levels {test, change, heal, feed}
    int                  hold_run;  // edges held since test press, -1 when not holding
    logic                fired;
    logic [3:0]          out;   // {test, healing, feeding, change_state}
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.hist     = '1;
    m.deb      = '1;
    m.hold_run = -1;
    m.fired    = 1'b0;
    m.out      = '0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, logic [3:0] raw);
    model_t     n;
    logic [3:0] press;
    logic       flip;
    logic       fire;
    n     = m;
    press = '0;
    fire  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      // The synchronized value seen on this edge is the raw sample from two edges ago.
      flip = 1'b1;
      for (int k = 1; k <= int'(DEB) + 1; k++) begin
        if (m.hist[b][k] == m.deb[b]) flip = 1'b0;
      end
      if (flip) begin
        n.deb[b] = ~m.deb[b];
        press[b] = m.deb[b];
      end
      n.hist[b] = {m.hist[b][DEB:0], raw[b]};
    end
    if (press[3]) begin
      n.hold_run = 0;
      n.fired    = 1'b0;
    end else if (n.deb[3]) begin
      n.hold_run = -1;
    end else if (m.hold_run >= 0 && !m.fired) begin
      n.hold_run = m.hold_run + 1;
      if (n.hold_run == int'(HOLD)) begin
        fire    = 1'b1;
        n.fired = 1'b1;
      end
    end
    if (fire)          n.out = 4'b1000;
    else if (press[1]) n.out = 4'b0100;
    else if (press[0]) n.out = 4'b0010;
    else if (press[2]) n.out = 4'b0001;
    else               n.out = 4'b0000;
    return n;
  endfunction

  model_t ref_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) ref_m <= model_reset();
    else      ref_m <= model_next(ref_m, {btn_test, btn_change, btn_heal, btn_feed});
  end

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    int first;
    rst = 1'b0;
    {btn_test, btn_change, btn_heal, btn_feed} = 4'b0000;
    #1;
    n_checks++;
    if (dut_out !== 4'b0000) $display("FAIL reset_initial got %b want 0000", dut_out);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== 4'b0000) $display("FAIL reset_held cyc=%0d got %b want 0000", cyc, dut_out);
      else n_pass++;
    end
    {btn_test, btn_change, btn_heal, btn_feed} = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL reset_idle cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
    end
    // Catch a live pulse, then pull reset mid-cycle: it must clear without a clock.
    btn_feed = 1'b0;
    first = cyc + 1;
    while (cyc < first + 6) @(negedge clk);
    n_checks++;
    if (feeding !== 1'b1) $display("FAIL reset_pulse_before got %b want 1", feeding);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (dut_out !== 4'b0000) $display("FAIL reset_async_clear got %b want 0000", dut_out);
    else n_pass++;
    @(negedge clk);
    btn_feed = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL reset_after cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    int first, seen, at;
    first = cyc + 1; seen = 0; at = -1;
    for (int i = 0; i < 50; i++) begin
      btn_feed = (i < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL clean_press cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      if (feeding) begin seen++; at = cyc; end
    end
    n_checks++;
    if (seen != 1 || at != first + 6)
      $display("FAIL clean_press_latency got %0d pulses at edge %0d want 1 at edge 7", seen, at - first + 1);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int first, seen, at;
    first = cyc + 1; seen = 0; at = -1;
    for (int i = 0; i < 70; i++) begin
      if (i < 20)      btn_heal = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else if (i < 50) btn_heal = 1'b0;
      else             btn_heal = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL bounce cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      if (healing) begin seen++; at = cyc; end
    end
    n_checks++;
    if (seen != 1 || at != first + 26)
      $display("FAIL bounce_pulse got %0d pulses at edge %0d want 1 at edge 7 of stable low", seen, at - first - 19);
    else n_pass++;
  endtask

  task automatic test_test_hold();
    int first, seen, at;
    first = cyc + 1; seen = 0; at = -1;
    for (int i = 0; i < 70; i++) begin
      btn_test = (i < 40) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL test_hold cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      if (test) begin seen++; at = cyc; end
    end
    n_checks++;
    if (seen != 1 || at != first + 26)
      $display("FAIL test_hold_fire got %0d pulses at %0d after press want 1 at 20", seen, at - first - 6);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      btn_test = (i < 10) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL test_short cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      if (test) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL test_short_nopulse got %0d pulses want 0", seen);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int first, n_feed, n_chg, at;
    first = cyc + 1; n_feed = 0; n_chg = 0; at = -1;
    for (int i = 0; i < 40; i++) begin
      btn_feed   = (i < 20) ? 1'b0 : 1'b1;
      btn_change = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL simultaneous cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      if (feeding) begin n_feed++; at = cyc; end
      if (change_state) n_chg++;
    end
    n_checks++;
    if (n_feed != 1 || at != first + 6 || n_chg != 0)
      $display("FAIL simultaneous_priority got feed=%0d change=%0d want feed=1 change=0", n_feed, n_chg);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int first, seen, at;
    first = cyc + 1; seen = 0; at = -1;
    for (int i = 0; i < 80; i++) begin
      btn_test = (i < 60) ? 1'b0 : 1'b1;
      rst      = (i >= 17 && i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL reset_mid_hold cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      if (test) begin seen++; at = cyc; end
    end
    n_checks++;
    if (seen != 1 || at != first + 46)
      $display("FAIL reset_mid_hold_fire got %0d pulses at %0d after release want 1 at 27", seen, at - first - 19);
    else n_pass++;
  endtask

  task automatic test_concurrency();
    int n_feed, n_test, last_feed, at_test;
    n_feed = 0; n_test = 0; last_feed = -1; at_test = -1;
    for (int i = 0; i < 70; i++) begin
      btn_test = (i < 40) ? 1'b0 : 1'b1;
      btn_feed = ((i < 8) || (i >= 16 && i < 24)) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL concurrency cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      n_checks++;
      if ($countones(dut_out) > 1) $display("FAIL concurrency_onehot cyc=%0d got %b want at most one bit", cyc, dut_out);
      else n_pass++;
      if (feeding) begin n_feed++; last_feed = cyc; end
      if (test) begin n_test++; at_test = cyc; end
    end
    n_checks++;
    if (n_feed != 2 || n_test != 1 || last_feed >= at_test)
      $display("FAIL concurrency_counts got feed=%0d test=%0d want feed=2 then test=1", n_feed, n_test);
    else n_pass++;
  endtask

  task automatic test_random();
    int         left [4];
    int         rst_left;
    logic [3:0] lvl;
    lvl = 4'hF; rst_left = 0;
    for (int b = 0; b < 4; b++) left[b] = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++) begin
        left[b]--;
        if (left[b] <= 0) begin
          lvl[b]  = ~lvl[b];
          left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 12));
        end
      end
      {btn_test, btn_change, btn_heal, btn_feed} = lvl;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst      = 1'b0;
        rst_left = int'($urandom_range(1, 3));
      end
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL random cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
      n_checks++;
      if ($countones(dut_out) > 1) $display("FAIL random_onehot cyc=%0d got %b want at most one bit", cyc, dut_out);
      else n_pass++;
    end
    rst = 1'b1;
    {btn_test, btn_change, btn_heal, btn_feed} = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_out !== ref_m.out) $display("FAIL random_drain cyc=%0d got %b want %b", cyc, dut_out, ref_m.out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_test_hold();
    test_simultaneous();
    test_reset_mid_hold();
    test_concurrency();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
